fifo_ctrl: RTL and testbench

Pointer and status controller for the 16-entry, 10-bit transaction-layer FIFO. Converts the producer's `wr` and consumer's `rd` requests into the write enable and 5-bit write/read pointers that drive the FIFO storage array. Generates full/empty/almost flags, a fill count and sticky overflow/underflow errors. Sits directly upstream of the storage array, inside the FIFO top level.

---
 rtl/fifo_ctrl_pkg.sv | 6 +
 rtl/fifo_ptr_cnt.sv | 37 +++
 rtl/fifo_ctrl.sv | 88 ++++++++
 tb/tb_fifo_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing constants for the 16-entry transaction-layer FIFO.
package fifo_ctrl_pkg;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int PTR_W  = ADDR_W + 1;
endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrap-bit pointer register: increments modulo 2**W, with synchronous clear.
module fifo_ptr_cnt
    import fifo_ctrl_pkg::*;
#(
    parameter int W = PTR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            // Carry out of the address bits naturally toggles the wrap bit.
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer, status-flag and sticky-error controller sitting in front of the FIFO storage array.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic              flush,
    input  logic              clr_err,
    output logic              fifo_we,
    output logic [PTR_W-1:0]  wptr,
    output logic [PTR_W-1:0]  rptr,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [PTR_W-1:0]  fill_count,
    output logic              fifo_overflow,
    output logic              fifo_underflow
);

    localparam logic [PTR_W-1:0] AF_CNT = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_CNT = PTR_W'(AE_LEVEL);

    logic we_ok;
    logic re_ok;
    logic ovf_set;
    logic unf_set;
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    assign we_ok = wr & ~fifo_full;
    assign re_ok = rd & ~fifo_empty;

    // Flush wins over both requests; rst_n gating keeps the array quiet during reset.
    assign fifo_we = we_ok & ~flush & rst_n;

    fifo_ptr_cnt #(.W(PTR_W)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (we_ok),
        .ptr   (wptr)
    );

    fifo_ptr_cnt #(.W(PTR_W)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (re_ok),
        .ptr   (rptr)
    );

    assign fill_count   = wptr - rptr;
    assign fifo_empty   = (wptr == rptr);
    assign fifo_full    = (wptr[ADDR_W] != rptr[ADDR_W]) &
                          (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign almost_full  = (fill_count >= AF_CNT);
    assign almost_empty = (fill_count <= AE_CNT);

    assign ovf_set = wr & fifo_full  & ~flush;
    assign unf_set = rd & fifo_empty & ~flush;

    always_comb begin
        ovf_d = ovf_q & ~clr_err;
        unf_d = unf_q & ~clr_err;
        if (ovf_set) ovf_d = 1'b1;
        if (unf_set) unf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign fifo_overflow  = ovf_q;
    assign fifo_underflow = unf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl against a queue-based FIFO model.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0, rd = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [9:0] wdata = '0;
    logic       fifo_we, fifo_full, fifo_empty, almost_full, almost_empty;
    logic       fifo_overflow, fifo_underflow;
    logic [4:0] wptr, rptr, fill_count;

    fifo_ctrl #(.AF_LEVEL(12), .AE_LEVEL(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .flush(flush), .clr_err(clr_err),
        .fifo_we(fifo_we), .wptr(wptr), .rptr(rptr), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .fill_count(fill_count), .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow)
    );

    always #5 clk = ~clk;

    // Storage array driven by the DUT's write enable and pointers.
    logic [9:0] mem [16];
    always @(posedge clk) if (fifo_we) mem[wptr[3:0]] <= wdata;

    int total = 0;
    int bad = 0;

    logic [9:0] m_q [$];
    int         m_wp, m_rp;
    logic       m_ovf, m_unf;
    logic       obs_we, exp_we;

    task automatic mreset();
        m_q.delete();
        m_wp = 0; m_rp = 0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    // Apply one cycle of requests, sample fifo_we mid-cycle, advance the model at the edge.
    task automatic step(input logic w, input logic r, input logic f, input logic c, input logic [9:0] d);
        int n;
        bit we, re, os, us;
        wr = w; rd = r; flush = f; clr_err = c; wdata = d;
        #1;
        obs_we = fifo_we;
        n  = m_q.size();
        we = w && (n < 16);
        re = r && (n > 0);
        os = w && (n == 16) && !f;
        us = r && (n == 0) && !f;
        exp_we = we && !f;
        @(posedge clk);
        if (f) begin
            m_q.delete(); m_wp = 0; m_rp = 0;
        end else begin
            if (re) begin void'(m_q.pop_front()); m_rp = (m_rp + 1) % 32; end
            if (we) begin m_q.push_back(d); m_wp = (m_wp + 1) % 32; end
        end
        m_ovf = os ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf = us ? 1'b1 : (c ? 1'b0 : m_unf);
        #1;
        wr = 0; rd = 0; flush = 0; clr_err = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr = 1'b1;
        #3;
        total++; if (fifo_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", fifo_we); end
        total++; if (wptr !== 5'd0 || rptr !== 5'd0) begin bad++; $display("FAIL reset_ptr: got w=%0d r=%0d want 0/0", wptr, rptr); end
        total++; if (fifo_empty !== 1'b1 || almost_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got e=%b ae=%b want 1/1", fifo_empty, almost_empty); end
        total++; if ({fifo_full, almost_full, fifo_overflow, fifo_underflow} !== 4'b0 || fill_count !== 5'd0) begin
            bad++; $display("FAIL reset_misc: got full=%b af=%b ovf=%b unf=%b cnt=%0d want zeros", fifo_full, almost_full, fifo_overflow, fifo_underflow, fill_count);
        end
        wr = 1'b0;
        #9 rst_n = 1'b1;
        mreset();
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 0, 0, 10'($urandom));
            total++; if (obs_we !== 1'b1) begin bad++; $display("FAIL fill_we %0d: got %b want 1", i, obs_we); end
            total++; if (fill_count !== 5'(i)) begin bad++; $display("FAIL fill_count %0d: got %0d want %0d", i, fill_count, i); end
            total++; if (almost_full !== (i >= 12)) begin bad++; $display("FAIL fill_af %0d: got %b want %b", i, almost_full, i >= 12); end
            total++; if (almost_empty !== (i <= 4)) begin bad++; $display("FAIL fill_ae %0d: got %b want %b", i, almost_empty, i <= 4); end
        end
        total++; if (fifo_full !== 1'b1 || wptr !== 5'b10000 || rptr !== 5'd0) begin
            bad++; $display("FAIL fill_full: got full=%b w=%0d r=%0d want 1/16/0", fifo_full, wptr, rptr);
        end
    endtask

    task automatic test_overflow();
        step(1, 0, 0, 0, 10'h155);
        total++; if (obs_we !== 1'b0) begin bad++; $display("FAIL ovf_we: got %b want 0", obs_we); end
        total++; if (wptr !== 5'b10000) begin bad++; $display("FAIL ovf_wptr: got %0d want 16", wptr); end
        total++; if (fifo_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", fifo_overflow); end
        step(0, 0, 0, 0, '0);
        total++; if (fifo_overflow !== 1'b1) begin bad++; $display("FAIL ovf_hold: got %b want 1", fifo_overflow); end
        step(0, 0, 0, 1, '0);
        total++; if (fifo_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b want 0", fifo_overflow); end
        for (int i = 0; i < 16; i++) begin
            total++; if (mem[rptr[3:0]] !== m_q[0]) begin bad++; $display("FAIL drain_data %0d: got %h want %h", i, mem[rptr[3:0]], m_q[0]); end
            step(0, 1, 0, 0, '0);
        end
        total++; if (fifo_empty !== 1'b1 || fifo_underflow !== 1'b0) begin
            bad++; $display("FAIL drain_end: got e=%b unf=%b want 1/0", fifo_empty, fifo_underflow);
        end
    endtask

    task automatic test_underflow();
        step(0, 1, 0, 0, '0);
        total++; if (rptr !== 5'(m_rp)) begin bad++; $display("FAIL unf_rptr: got %0d want %0d", rptr, m_rp); end
        total++; if (fifo_underflow !== 1'b1) begin bad++; $display("FAIL unf_set: got %b want 1", fifo_underflow); end
        step(1, 0, 0, 0, 10'h2A3);
        total++; if (fifo_empty !== 1'b0) begin bad++; $display("FAIL unf_wr_empty: got %b want 0", fifo_empty); end
        total++; if (mem[rptr[3:0]] !== 10'h2A3) begin bad++; $display("FAIL fallthrough: got %h want 2a3", mem[rptr[3:0]]); end
        step(0, 1, 0, 1, '0);
        total++; if (fifo_empty !== 1'b1 || fifo_underflow !== 1'b0) begin
            bad++; $display("FAIL unf_clr: got e=%b unf=%b want 1/0", fifo_empty, fifo_underflow);
        end
    endtask

    task automatic test_simul();
        logic w4_start;
        while (m_q.size() < 8) step(1, 0, 0, 0, 10'($urandom));
        w4_start = wptr[4];
        for (int i = 0; i < 20; i++) begin
            total++; if (mem[rptr[3:0]] !== m_q[0]) begin bad++; $display("FAIL simul_data %0d: got %h want %h", i, mem[rptr[3:0]], m_q[0]); end
            step(1, 1, 0, 0, 10'($urandom));
            total++; if (fill_count !== 5'd8) begin bad++; $display("FAIL simul_count %0d: got %0d want 8", i, fill_count); end
            total++; if (wptr !== 5'(m_wp) || rptr !== 5'(m_rp)) begin bad++; $display("FAIL simul_ptr %0d: got w=%0d r=%0d want %0d/%0d", i, wptr, rptr, m_wp, m_rp); end
            total++; if (fifo_overflow !== 1'b0 || fifo_underflow !== 1'b0) begin bad++; $display("FAIL simul_err %0d: got ovf=%b unf=%b want 0/0", i, fifo_overflow, fifo_underflow); end
        end
        // 20 advances always cross the 16-entry boundary at least once.
        total++; if (wptr[4] !== (w4_start ^ (((m_wp + 12) % 32) < 20 ? 1'b0 : 1'b0) ^ 1'(((m_wp - 20 + 32) % 32) / 16 != m_wp / 16))) begin
            bad++; $display("FAIL simul_wrap: got w4=%b start=%b", wptr[4], w4_start);
        end
    endtask

    task automatic test_full_simul();
        while (m_q.size() < 16) step(1, 0, 0, 0, 10'($urandom));
        step(1, 1, 0, 0, 10'h3FF);
        total++; if (fill_count !== 5'd15) begin bad++; $display("FAIL fullsim_count: got %0d want 15", fill_count); end
        total++; if (fifo_overflow !== 1'b1) begin bad++; $display("FAIL fullsim_ovf: got %b want 1", fifo_overflow); end
        total++; if (rptr !== 5'(m_rp) || wptr !== 5'(m_wp) || obs_we !== 1'b0) begin
            bad++; $display("FAIL fullsim_ptr: got w=%0d r=%0d we=%b want %0d/%0d/0", wptr, rptr, obs_we, m_wp, m_rp);
        end
    endtask

    task automatic test_flush();
        while (m_q.size() > 10) step(0, 1, 0, 0, '0);
        step(1, 0, 1, 0, 10'h0AA);
        total++; if (obs_we !== 1'b0) begin bad++; $display("FAIL flush_we: got %b want 0", obs_we); end
        total++; if (wptr !== 5'd0 || rptr !== 5'd0 || fifo_empty !== 1'b1) begin
            bad++; $display("FAIL flush_ptr: got w=%0d r=%0d e=%b want 0/0/1", wptr, rptr, fifo_empty);
        end
        total++; if (fifo_overflow !== 1'b1 || fifo_underflow !== m_unf) begin
            bad++; $display("FAIL flush_sticky: got ovf=%b unf=%b want 1/%b", fifo_overflow, fifo_underflow, m_unf);
        end
    endtask

    task automatic test_async_reset();
        step(0, 0, 0, 1, '0);
        while (m_q.size() < 16) step(1, 0, 0, 0, 10'($urandom));
        step(1, 0, 0, 0, 10'h001);
        wr = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        total++; if (fifo_we !== 1'b0 || wptr !== 5'd0 || rptr !== 5'd0 || fill_count !== 5'd0) begin
            bad++; $display("FAIL areset_ptr: got we=%b w=%0d r=%0d cnt=%0d want 0", fifo_we, wptr, rptr, fill_count);
        end
        total++; if ({fifo_empty, almost_empty, fifo_full, almost_full, fifo_overflow, fifo_underflow} !== 6'b110000) begin
            bad++; $display("FAIL areset_flags: got %b want 110000", {fifo_empty, almost_empty, fifo_full, almost_full, fifo_overflow, fifo_underflow});
        end
        #2 rst_n = 1'b1; wr = 1'b0;
        mreset();
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic w, r, f, c;
        for (int i = 0; i < 400; i++) begin
            w = ($urandom % 4) < ((i / 50) % 2 == 0 ? 3 : 1);
            r = ($urandom % 4) < ((i / 50) % 2 == 0 ? 1 : 3);
            f = ($urandom % 40) == 0;
            c = ($urandom % 16) == 0;
            if (m_q.size() > 0) begin
                total++; if (mem[rptr[3:0]] !== m_q[0]) begin bad++; $display("FAIL rnd_data %0d: got %h want %h", i, mem[rptr[3:0]], m_q[0]); end
            end
            step(w, r, f, c, 10'($urandom));
            total++; if (obs_we !== exp_we) begin bad++; $display("FAIL rnd_we %0d: got %b want %b", i, obs_we, exp_we); end
            total++; if (wptr !== 5'(m_wp) || rptr !== 5'(m_rp)) begin bad++; $display("FAIL rnd_ptr %0d: got w=%0d r=%0d want %0d/%0d", i, wptr, rptr, m_wp, m_rp); end
            total++; if (fill_count !== 5'(m_q.size())) begin bad++; $display("FAIL rnd_count %0d: got %0d want %0d", i, fill_count, m_q.size()); end
            total++; if ({fifo_full, fifo_empty, almost_full, almost_empty} !==
                         {m_q.size() == 16, m_q.size() == 0, m_q.size() >= 12, m_q.size() <= 4}) begin
                bad++; $display("FAIL rnd_flags %0d: got %b%b%b%b cnt=%0d", i, fifo_full, fifo_empty, almost_full, almost_empty, m_q.size());
            end
            total++; if (fifo_overflow !== m_ovf || fifo_underflow !== m_unf) begin
                bad++; $display("FAIL rnd_err %0d: got ovf=%b unf=%b want %b/%b", i, fifo_overflow, fifo_underflow, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        mreset();
        test_reset();
        test_fill();
        test_overflow();
        test_underflow();
        test_simul();
        test_full_simul();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
